// File: rtl/cdr_gear_if.sv
// Control/status bundle between the CDR gear sequencer and its driver.
interface cdr_gear_if #(
    parameter int WIN_LOG2 = 6
);
    logic                     enable;
    logic                     force_relock;
    logic                     sample_en;
    logic signed [15:0]       phi;
    logic [4:0]               kp_shift;
    logic [4:0]               ki_shift;
    logic                     filter_clr;
    logic [1:0]               state;
    logic                     locked;
    logic                     lol_pulse;
    logic [15+WIN_LOG2:0]     win_sum;

    modport master (
        output enable, force_relock, sample_en, phi,
        input  kp_shift, ki_shift, filter_clr, state, locked, lol_pulse, win_sum
    );

    modport slave (
        input  enable, force_relock, sample_en, phi,
        output kp_shift, ki_shift, filter_clr, state, locked, lol_pulse, win_sum
    );
endinterface

// File: rtl/cdr_gear_ctrl.sv
// Acquisition/lock sequencer for the baud-rate CDR loop filter gains.
//
// state  | meaning
// IDLE   | sequencer disabled, acquisition gains
// ACQ    | counting ACQ_UI strobes with high-gain (small shift) filter
// TRACK  | low gain, waiting for LOCK_WINS consecutive quiet windows
// LOCKED | low gain, LOL_WINS consecutive noisy windows drop back to ACQ
module cdr_gear_ctrl #(
    parameter int WIN_LOG2   = 6,
    parameter int ACQ_UI     = 1024,
    parameter int LOCK_THR   = 2048,
    parameter int UNLOCK_THR = 8192,
    parameter int LOCK_WINS  = 4,
    parameter int LOL_WINS   = 2,
    parameter int KP_ACQ     = 8,
    parameter int KI_ACQ     = 14,
    parameter int KP_TRK     = 12,
    parameter int KI_TRK     = 18
) (
    input logic       clk,
    input logic       rst,
    cdr_gear_if.slave bus
);
    localparam int AW = 16 + WIN_LOG2;
    localparam logic [15:0]   ACQ_LAST = 16'(ACQ_UI - 1);
    localparam logic [AW-1:0] LOCK_T   = AW'(LOCK_THR);
    localparam logic [AW-1:0] UNLOCK_T = AW'(UNLOCK_THR);
    localparam logic [3:0]    LOCK_N   = 4'(LOCK_WINS);
    localparam logic [3:0]    LOL_N    = 4'(LOL_WINS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t              st;
    state_t              nxt;
    logic [15:0]         acq_cnt;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       win_sum_q;
    logic [3:0]          good_cnt;
    logic [3:0]          miss_cnt;
    logic                fclr_q;
    logic                lol_q;
    logic                force_q;

    logic [15:0]         neg;
    logic [14:0]         mag;
    logic [AW-1:0]       sum;
    logic                windowing;
    logic                win_close;
    logic                good;
    logic                miss;
    logic [3:0]          good_nxt;
    logic [3:0]          miss_nxt;
    logic                restart;
    logic                win_upd;
    logic                fclr_nxt;
    logic                lol_nxt;

    // Saturating |phi| and the running window sum including the current sample.
    always_comb begin
        neg = 16'(-bus.phi);
        mag = bus.phi[14:0];
        if (bus.phi == 16'sh8000) begin
            mag = 15'h7fff;
        end else if (bus.phi[15]) begin
            mag = neg[14:0];
        end
        sum       = acc + {{(AW-15){1'b0}}, mag};
        windowing = (st == TRACK) || (st == LOCKED);
        win_close = bus.sample_en && windowing && (win_cnt == {WIN_LOG2{1'b1}});
        good      = sum < LOCK_T;
        miss      = sum > UNLOCK_T;
        good_nxt  = good ? 4'(good_cnt + 4'd1) : 4'd0;
        miss_nxt  = miss ? 4'(miss_cnt + 4'd1) : 4'd0;
    end

    // Next-state with enable > force_relock > normal transition priority.
    always_comb begin
        nxt     = st;
        lol_nxt = 1'b0;
        if (!bus.enable) begin
            nxt = IDLE;
        end else if (bus.force_relock) begin
            nxt = ACQ;
        end else begin
            case (st)
                IDLE:   nxt = ACQ;
                ACQ:    if (bus.sample_en && acq_cnt == ACQ_LAST) nxt = TRACK;
                TRACK:  if (win_close && good && good_nxt == LOCK_N) nxt = LOCKED;
                LOCKED: if (win_close && miss && miss_nxt == LOL_N) begin
                            nxt     = ACQ;
                            lol_nxt = 1'b1;
                        end
                default: nxt = IDLE;
            endcase
        end
        restart  = (nxt != st) || !bus.enable || bus.force_relock;
        win_upd  = win_close && bus.enable && !bus.force_relock;
        // A fresh force_relock while already in ACQ restarts acquisition too.
        fclr_nxt = (nxt == ACQ) &&
                   ((st != ACQ) || (bus.enable && bus.force_relock && !force_q));
    end

    // State register and the one-clk pulses aligned with state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            fclr_q  <= 1'b0;
            lol_q   <= 1'b0;
            force_q <= 1'b0;
        end else begin
            st      <= nxt;
            fclr_q  <= fclr_nxt;
            lol_q   <= lol_nxt;
            force_q <= bus.force_relock;
        end
    end

    // Strobe counters, window accumulator and the published window sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            acq_cnt   <= '0;
            win_cnt   <= '0;
            acc       <= '0;
            good_cnt  <= '0;
            miss_cnt  <= '0;
            win_sum_q <= '0;
        end else begin
            if (win_upd) begin
                win_sum_q <= sum;
            end
            if (restart) begin
                acq_cnt  <= '0;
                win_cnt  <= '0;
                acc      <= '0;
                good_cnt <= '0;
                miss_cnt <= '0;
            end else if (bus.sample_en) begin
                if (st == ACQ) begin
                    acq_cnt <= acq_cnt + 16'd1;
                end else if (windowing) begin
                    if (win_close) begin
                        acc     <= '0;
                        win_cnt <= '0;
                        if (st == TRACK) begin
                            good_cnt <= good_nxt;
                        end else begin
                            miss_cnt <= miss_nxt;
                        end
                    end else begin
                        acc     <= sum;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Gains decode straight from the state register.
    assign bus.kp_shift   = (st == TRACK || st == LOCKED) ? 5'(KP_TRK) : 5'(KP_ACQ);
    assign bus.ki_shift   = (st == TRACK || st == LOCKED) ? 5'(KI_TRK) : 5'(KI_ACQ);
    assign bus.filter_clr = fclr_q;
    assign bus.lol_pulse  = lol_q;
    assign bus.state      = st;
    assign bus.locked     = (st == LOCKED);
    assign bus.win_sum    = win_sum_q;
endmodule

// File: tb/tb_cdr_gear_ctrl.sv
// Self-checking bench for cdr_gear_ctrl: directed vector table, hand corner
// sequences and randomized traffic, all checked against a behavioural model.
module tb_cdr_gear_ctrl;
    localparam int WIN_LOG2   = 2;
    localparam int WIN        = 4;
    localparam int ACQ_UI     = 8;
    localparam int LOCK_THR   = 40;
    localparam int UNLOCK_THR = 200;
    localparam int LOCK_WINS  = 2;
    localparam int LOL_WINS   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdr_gear_if #(.WIN_LOG2(WIN_LOG2)) bus ();

    cdr_gear_ctrl #(
        .WIN_LOG2(WIN_LOG2), .ACQ_UI(ACQ_UI), .LOCK_THR(LOCK_THR),
        .UNLOCK_THR(UNLOCK_THR), .LOCK_WINS(LOCK_WINS), .LOL_WINS(LOL_WINS),
        .KP_ACQ(8), .KI_ACQ(14), .KP_TRK(12), .KI_TRK(18)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // driven values
    logic               drv_rst;
    logic               drv_en;
    logic               drv_frc;
    logic               drv_se;
    logic signed [15:0] drv_phi;

    // behavioural model
    int     m_state;
    int     m_acq;
    int     m_good;
    int     m_miss;
    int     win_q[$];
    longint m_win_sum;
    bit     m_fclr;
    bit     m_lol;
    bit     m_frc_prev;

    int fcnt;
    int lcnt;

    typedef struct {
        int n;
        int ph;
        int exp_state;
        int exp_sum;
        int exp_fclr;
        int exp_lol;
    } vec_t;
    vec_t vecs[17];

    task automatic chk(string name, longint act, longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int mag(logic signed [15:0] p);
        int v;
        v = int'(p);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_acq = 0; m_good = 0; m_miss = 0; win_q.delete();
        m_win_sum = 0; m_fclr = 0; m_lol = 0; m_frc_prev = 0;
    endtask

    task automatic model_step();
        int  ns;
        int  mg;
        int  s;
        bit  close;
        if (drv_rst) begin
            model_reset();
            return;
        end
        mg = mag(drv_phi);
        close = 0;
        s = 0;
        ns = m_state;
        m_lol = 0;
        if (drv_se && m_state >= 2 && win_q.size() == WIN - 1) begin
            close = 1;
            s = mg;
            foreach (win_q[i]) s += win_q[i];
        end
        if (!drv_en) ns = 0;
        else if (drv_frc) ns = 1;
        else begin
            case (m_state)
                0: ns = 1;
                1: if (drv_se && m_acq + 1 == ACQ_UI) ns = 2;
                2: if (close && s < LOCK_THR && m_good + 1 == LOCK_WINS) ns = 3;
                default: if (close && s > UNLOCK_THR && m_miss + 1 == LOL_WINS) begin
                        ns = 1;
                        m_lol = 1;
                    end
            endcase
        end
        m_fclr = (ns == 1) && (m_state != 1 || (drv_en && drv_frc && !m_frc_prev));
        if (close && drv_en && !drv_frc) m_win_sum = s;
        if (ns != m_state || !drv_en || drv_frc) begin
            m_acq = 0; m_good = 0; m_miss = 0; win_q.delete();
        end else if (drv_se) begin
            if (m_state == 1) m_acq++;
            else if (m_state >= 2) begin
                if (close) begin
                    win_q.delete();
                    if (m_state == 2) m_good = (s < LOCK_THR) ? m_good + 1 : 0;
                    else              m_miss = (s > UNLOCK_THR) ? m_miss + 1 : 0;
                end else begin
                    win_q.push_back(mg);
                end
            end
        end
        m_frc_prev = drv_frc;
        m_state = ns;
    endtask

    // One clock: apply drives, clock, then compare the DUT against the model.
    task automatic tick();
        rst              = drv_rst;
        bus.enable       = drv_en;
        bus.force_relock = drv_frc;
        bus.sample_en    = drv_se;
        bus.phi          = drv_phi;
        @(posedge clk);
        #1;
        model_step();
        if (bus.filter_clr) fcnt++;
        if (bus.lol_pulse)  lcnt++;
        chk("cyc_state", longint'(bus.state), m_state);
        chk("cyc_win_sum", longint'(bus.win_sum), m_win_sum);
        chk("cyc_filter_clr", longint'(bus.filter_clr), m_fclr);
        chk("cyc_lol_pulse", longint'(bus.lol_pulse), m_lol);
        chk("cyc_locked", longint'(bus.locked), (m_state == 3) ? 1 : 0);
        chk("cyc_kp", longint'(bus.kp_shift), (m_state >= 2) ? 12 : 8);
        chk("cyc_ki", longint'(bus.ki_shift), (m_state >= 2) ? 18 : 14);
    endtask

    // n strobes, one every two clocks, with junk phi between strobes.
    task automatic strobes(int n, int ph);
        for (int k = 0; k < n; k++) begin
            drv_se  = 1'b1;
            drv_phi = 16'(ph);
            tick();
            drv_se  = 1'b0;
            drv_phi = 16'($urandom);
            tick();
        end
    endtask

    initial begin
        vecs[0]  = '{7,  0,      1, 0,      0, 0};
        vecs[1]  = '{1,  0,      2, 0,      0, 0};
        vecs[2]  = '{4,  5,      2, 20,     0, 0};
        vecs[3]  = '{4,  5,      3, 20,     0, 0};
        vecs[4]  = '{4,  -25,    3, 100,    0, 0};
        vecs[5]  = '{4,  100,    3, 400,    0, 0};
        vecs[6]  = '{4,  5,      3, 20,     0, 0};
        vecs[7]  = '{4,  100,    3, 400,    0, 0};
        vecs[8]  = '{4,  5,      3, 20,     0, 0};
        vecs[9]  = '{4,  100,    3, 400,    0, 0};
        vecs[10] = '{4,  100,    1, 400,    1, 1};
        vecs[11] = '{8,  0,      2, 400,    0, 0};
        vecs[12] = '{4,  -25,    2, 100,    0, 0};
        vecs[13] = '{8,  -25,    2, 100,    0, 0};
        vecs[14] = '{4,  -32768, 2, 131068, 0, 0};
        vecs[15] = '{4,  5,      2, 20,     0, 0};
        vecs[16] = '{4,  5,      3, 20,     0, 0};

        model_reset();
        drv_rst = 1'b1; drv_en = 1'b0; drv_frc = 1'b0; drv_se = 1'b0; drv_phi = '0;
        fcnt = 0; lcnt = 0;
        repeat (3) tick();
        chk("rst_state", longint'(bus.state), 0);
        chk("rst_kp", longint'(bus.kp_shift), 8);
        chk("rst_ki", longint'(bus.ki_shift), 14);
        chk("rst_win_sum", longint'(bus.win_sum), 0);
        chk("rst_filter_clr", longint'(bus.filter_clr), 0);
        drv_rst = 1'b0;
        tick();
        chk("idle_hold", longint'(bus.state), 0);

        drv_en = 1'b1;
        tick();
        chk("start_state", longint'(bus.state), 1);
        chk("start_filter_clr", longint'(bus.filter_clr), 1);

        for (int v = 0; v < 17; v++) begin
            fcnt = 0; lcnt = 0;
            strobes(vecs[v].n, vecs[v].ph);
            chk($sformatf("vec%0d_state", v), longint'(bus.state), vecs[v].exp_state);
            chk($sformatf("vec%0d_win_sum", v), longint'(bus.win_sum), vecs[v].exp_sum);
            chk($sformatf("vec%0d_fclr_cnt", v), fcnt, vecs[v].exp_fclr);
            chk($sformatf("vec%0d_lol_cnt", v), lcnt, vecs[v].exp_lol);
            chk($sformatf("vec%0d_locked", v), longint'(bus.locked),
                (vecs[v].exp_state == 3) ? 1 : 0);
        end

        // LOCKED: force_relock and enable drop together -> IDLE, no pulses.
        drv_en = 1'b0; drv_frc = 1'b1;
        tick();
        chk("prio_state", longint'(bus.state), 0);
        chk("prio_lol", longint'(bus.lol_pulse), 0);
        chk("prio_fclr", longint'(bus.filter_clr), 0);
        drv_en = 1'b1; drv_frc = 1'b0;
        tick();
        chk("reen_state", longint'(bus.state), 1);
        chk("reen_fclr", longint'(bus.filter_clr), 1);
        strobes(3, 0);
        fcnt = 0;
        drv_frc = 1'b1;
        strobes(5, 0);
        chk("force_fclr_cnt", fcnt, 1);
        chk("force_state", longint'(bus.state), 1);
        drv_frc = 1'b0;
        fcnt = 0;
        strobes(7, 0);
        chk("release_acq", longint'(bus.state), 1);
        strobes(1, 0);
        chk("release_track", longint'(bus.state), 2);
        chk("release_fclr_cnt", fcnt, 0);

        // Enable drop mid-window discards the partial sum.
        strobes(2, 7);
        drv_en = 1'b0;
        tick();
        chk("abort_state", longint'(bus.state), 0);
        chk("abort_win_sum", longint'(bus.win_sum), 20);
        drv_en = 1'b1;
        tick();
        strobes(8, 0);
        strobes(4, 1);
        chk("abort_fresh_win", longint'(bus.win_sum), 4);

        // Randomized traffic against the model.
        begin
            int mode;
            int ph;
            mode = 0;
            for (int c = 0; c < 6000; c++) begin
                if (c % 40 == 0) mode = int'($urandom_range(0, 5));
                drv_rst = ($urandom_range(0, 999) < 2);
                drv_en  = ($urandom_range(0, 999) >= 8);
                drv_frc = ($urandom_range(0, 999) < 6);
                drv_se  = (mode == 5) ? ($urandom_range(0, 1) == 1) : (c % 2 == 0);
                case (mode)
                    0, 1: ph = int'($urandom_range(0, 18)) - 9;
                    2:    ph = int'($urandom_range(0, 120)) - 60;
                    3:    ph = ($urandom_range(0, 1) == 1) ? int'($urandom_range(50, 300))
                                                           : -int'($urandom_range(50, 300));
                    4:    ph = ($urandom_range(0, 3) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
                    default: ph = int'($urandom_range(0, 40)) - 20;
                endcase
                drv_phi = 16'(ph);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cdr_gear_ctrl.md
Name: cdr_gear_ctrl

Overview:
Acquisition/lock sequencer for the baud-rate PAM4 CDR loop. It watches the Mueller–Müller phase-detector output at each symbol strobe and gear-shifts the PI loop filter. Acquisition uses high gain (small shifts), tracking uses low gain. The block declares lock from windowed |PHI| energy and drives the loop back to acquisition on loss of lock. It sits beside the loop filter and supplies its shift amounts and a clear pulse.

Parameters:
WIN_LOG2, 6, log2 of window length in UIs (sample strobes)
ACQ_UI, 1024, strobes spent in ACQ before TRACK (1..2^16-1)
LOCK_THR, 2048, window |PHI| sum strictly below this counts as a good window
UNLOCK_THR, 8192, window sum strictly above this counts as a miss; must be >= LOCK_THR
LOCK_WINS, 4, consecutive good windows needed for TRACK->LOCKED (1..15)
LOL_WINS, 2, consecutive misses needed for LOCKED->ACQ (1..15)
KP_ACQ, 8, proportional shift in IDLE/ACQ
KI_ACQ, 14, integral shift in IDLE/ACQ
KP_TRK, 12, proportional shift in TRACK/LOCKED
KI_TRK, 18, integral shift in TRACK/LOCKED

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  run the sequencer; 0 forces IDLE
force_relock  in  1  level; restart acquisition
sample_en  in  1  one-clk symbol strobe from DCO
phi  in  16  signed PD output, valid when sample_en=1
kp_shift  out  5  filter proportional shift
ki_shift  out  5  filter integral shift
filter_clr  out  1  one-clk pulse, clears filter accumulators
state  out  2  IDLE=0, ACQ=1, TRACK=2, LOCKED=3
locked  out  1  high iff state==LOCKED
lol_pulse  out  1  one-clk pulse on loss-of-lock exit
win_sum  out  16+WIN_LOG2  last completed window |PHI| sum

Behaviour:
- Reset (rst, synchronous, active-high, clock clk):
  - state=IDLE; filter_clr=0; lol_pulse=0; win_sum=0.
  - All internal counters and the accumulator are 0.
  - kp_shift=KP_ACQ, ki_shift=KI_ACQ.
- Gains decode directly from the state register. IDLE/ACQ give KP_ACQ/KI_ACQ. TRACK/LOCKED give KP_TRK/KI_TRK. Gains change on the same clk as state. locked = (state==3).
- Transition priority each clk: rst > enable==0 (go to IDLE) > force_relock (go to ACQ) > normal transitions.
- IDLE: if enable=1, go to ACQ on the next clk. No sample_en is needed.
- Any entry into ACQ (from IDLE, force, or LOL) pulses filter_clr for exactly one clk, coincident with state becoming ACQ. While force_relock is held, stay in ACQ with acq_cnt held at 0. filter_clr pulses only once, on the entry clk.
- ACQ: acq_cnt increments on each sample_en. On the sample_en where acq_cnt==ACQ_UI-1, go to TRACK.
- Magnitude: |phi| saturates, so -32768 maps to 32767 (15-bit unsigned). The accumulator is 16+WIN_LOG2 bits and cannot overflow.
- Window (TRACK and LOCKED only): on each sample_en, acc += |phi| and win_cnt++.
- Window close: on the sample_en where win_cnt==2^WIN_LOG2-1, the window closes.
  - sum = acc + |phi|, including the current sample.
  - win_sum <= sum; acc <= 0; win_cnt <= 0.
  - The window is then evaluated.
- TRACK evaluation:
  - sum < LOCK_THR: good_cnt++; otherwise good_cnt=0.
  - If good_cnt reaches LOCK_WINS, go to LOCKED.
- LOCKED evaluation:
  - sum > UNLOCK_THR: miss_cnt++; otherwise miss_cnt=0.
  - If miss_cnt reaches LOL_WINS, go to ACQ and assert lol_pulse for one clk, together with filter_clr.
  - Sums in [LOCK_THR, UNLOCK_THR] are hysteresis: they keep LOCKED and reset miss_cnt.
- Every state change clears acq_cnt, win_cnt, acc, good_cnt and miss_cnt. win_sum holds its value.
- sample_en outside ACQ/TRACK/LOCKED is ignored. phi is ignored when sample_en=0.
- force_relock from LOCKED does not assert lol_pulse. Dropping enable mid-window discards the partial window without updating win_sum.

Test Plan:
Bench params: WIN_LOG2=2, ACQ_UI=8, LOCK_WINS=2, LOL_WINS=2, LOCK_THR=40, UNLOCK_THR=200, strobe every 2 clks.
- Start-up: rst 3 clks, then enable=1 → next clk state=1, filter_clr high exactly 1 clk, kp=8, ki=14. After the 8th strobe: state=2, kp=12, ki=18, filter_clr stays 0.
- Lock: in TRACK, phi=+5 every strobe → win_sum=20 after strobe 4; state=3 and locked=1 after strobe 8.
- Hysteresis: in TRACK, phi=-25 → win_sum=100 and state stays 2 indefinitely. Once LOCKED, phi=-25 keeps state=3.
- LOL: in LOCKED, phi=+100 (sum 400) for 2 windows → lol_pulse and filter_clr both 1 clk, state=1, locked=0. Alternate bad window / good window (sum 20) → stays LOCKED.
- Saturation: in TRACK, phi=-32768 for 4 strobes → win_sum=131068, no wrap, good_cnt=0.
- Priority and abort: in LOCKED assert force_relock and drop enable on the same clk → state=0, no lol_pulse, no filter_clr. Re-enable → ACQ with one filter_clr. Mid-ACQ force_relock held 5 strobes → stays ACQ with one filter_clr, then TRACK 8 strobes after release.
